uart_tx_param: RTL

Parametrised UART transmitter. It drains bytes from a standard read-latency-1 FIFO and serialises them onto a single TX line. Data width, stop-bit count, baud rate and parity are all configurable. Bit timing comes from a clock-enable divider running on clk, so the block generates no derived clocks. It replaces the fixed 8N1 transmitter in the host-link path.

---
 rtl/uart_tx_param_if.sv | 18 +
 rtl/uart_tx_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param_if.sv
// FIFO read-port bundle between uart_tx_param and a read-latency-1 FIFO.
//
// Handshake: the transmitter (master) raises readEn for exactly one clk, and
// only when empty was 0 at that edge. The FIFO (slave) presents the word on
// dout during the following cycle. empty is level-sensitive and may change at
// any time; the transmitter looks at it only when it is ready for a new word.
// state mirrors the transmitter FSM encoding so checkers can observe it.
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 readEn;
   logic [DATA_BITS-1:0] dout;
   logic                 empty;
   logic [2:0]           state;

   modport master (output readEn, output state, input dout, input empty);
   modport slave  (input readEn, input state, output dout, output empty);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter draining a read-latency-1 FIFO.
// Bit timing uses a clock-enable baud counter on clk (no derived clocks).
// Optional parity: define UART_TX_PARITY_EN to build the PARITY state and
// accumulator; PARITY_ODD selects odd (1) or even (0) sense.
module uart_tx_param #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_param_if.master fifo,
   output logic            txData,
   output logic            busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W        = 4;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_tx_param: CLKS_PER_BIT must be >= 4");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 rd_q, rd_d;
   logic                 busy_q, busy_d;
   logic                 bit_done;

`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`else
   // Parity sense is meaningless without the parity stage.
   logic                 unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   // One serial bit lasts CLKS_PER_BIT clks; bit_done marks its last clk.
   assign bit_done = (baud_q == CNT_MAX);

   assign txData      = tx_q;
   assign busy        = busy_q;
   assign fifo.readEn = rd_q;
   assign fifo.state  = state_q;

   // State and datapath registers; reset forces the line idle and drops any fetched word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state and registered-output logic. Every state change happens either
   // on bit_done (counter wraps to 0) or from a state that holds the counter at
   // 0, so the baud counter always starts from 0 on state entry.
   always_comb begin
      state_d = state_q;
      baud_d  = bit_done ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      rd_d    = 1'b0;
      busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (!fifo.empty) begin
               rd_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            baud_d  = '0;
            state_d = LOAD;
         end
         LOAD: begin
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo.dout;
`ifdef UART_TX_PARITY_EN
            par_d   = (PARITY_ODD != 0);
`endif
            tx_d    = 1'b0;
            state_d = START;
         end
         START: begin
            if (bit_done) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
               par_d   = par_q ^ shift_q[0];
`endif
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q ^ shift_q[0];
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_done) begin
               if (bit_q == LAST_STOP) begin
                  bit_d = '0;
                  if (!fifo.empty) begin
                     // Back-to-back: FETCH and LOAD stretch the stop period by 2 clks.
                     rd_d    = 1'b1;
                     state_d = FETCH;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            baud_d  = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule
